// File: rtl/mem_bus_ctrl_if.sv
// CPU-side request/response bundle for mem_bus_ctrl.
// The controller takes the slave view; the CPU (or bench) takes the master view.
interface mem_bus_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) ();
    logic              req;
    logic              wr;
    logic              inc;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport slave (
        input  req, wr, inc, addr_in, wdata,
        output rdata, ack, busy, err
    );

    modport master (
        output req, wr, inc, addr_in, wdata,
        input  rdata, ack, busy, err
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// MAR/MDR bus controller in front of the 64K SAP-II memory (IDLE -> ADDR -> XFER -> DONE).
// Optional ROM write protection is enabled by defining MEM_ROM_PROTECT_EN.
module mem_bus_ctrl #(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 8,
    parameter logic [ADDR_W-1:0] ROM_TOP = 16'h07FF
) (
    input  logic                CLK,
    input  logic                RST,
    mem_bus_ctrl_if.slave       cpu,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_nCE,
    inout  wire  [DATA_W-1:0]   mem_data
);

`ifdef MEM_ROM_PROTECT_EN
    localparam bit PROTECT_EN = 1'b1;
`else
    localparam bit PROTECT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] mar_r, mar_s;
    logic [DATA_W-1:0] mdr_r, mdr_s;
    logic              wr_r, wr_s;
    logic              nce_r, nce_s;
    logic              ack_r, ack_s;
    logic              busy_r, busy_s;
    logic              err_r, err_s;

    // Address lies in the write-protected monitor region (always false when protection is off).
    function automatic logic rom_hit(input logic [ADDR_W-1:0] addr);
        return PROTECT_EN && (addr <= ROM_TOP);
    endfunction

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_s = state_r;
        mar_s   = mar_r;
        mdr_s   = mdr_r;
        wr_s    = wr_r;
        nce_s   = 1'b1;
        ack_s   = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cpu.req) begin
                    state_s = ST_ADDR;
                    mar_s   = cpu.inc ? (mar_r + {{(ADDR_W-1){1'b0}}, 1'b1}) : cpu.addr_in;
                    wr_s    = cpu.wr;
                    if (cpu.wr) begin
                        mdr_s = cpu.wdata;
                    end else begin
                        mdr_s = mdr_r;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_s = ST_XFER;
                // Only an unprotected write pulls nCE low; the bus is driven only in that cycle.
                if (wr_r && !rom_hit(mar_r)) begin
                    nce_s = 1'b0;
                end else begin
                    nce_s = 1'b1;
                end
            end
            ST_XFER: begin
                state_s = ST_DONE;
                ack_s   = 1'b1;
                err_s   = wr_r && rom_hit(mar_r);
                if (!wr_r) begin
                    mdr_s = mem_data;
                end else begin
                    mdr_s = mdr_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, MAR/MDR and registered outputs with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            mar_r   <= {ADDR_W{1'b0}};
            mdr_r   <= {DATA_W{1'b0}};
            wr_r    <= 1'b0;
            nce_r   <= 1'b1;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            mar_r   <= mar_s;
            mdr_r   <= mdr_s;
            wr_r    <= wr_s;
            nce_r   <= nce_s;
            ack_r   <= ack_s;
            busy_r  <= busy_s;
            err_r   <= err_s;
        end
    end

    // The memory drives the bus whenever nCE is high, so we drive strictly while it is low.
    assign mem_data  = nce_r ? {DATA_W{1'bz}} : mdr_r;
    assign mem_addr  = mar_r;
    assign mem_nCE   = nce_r;
    assign cpu.rdata = mdr_r;
    assign cpu.ack   = ack_r;
    assign cpu.busy  = busy_r;
    assign cpu.err   = err_r;

endmodule
